hex_reporter: RTL and testbench

HEX_REPORTER -- requirements
Module: hex_reporter

---
 rtl/hex_reporter_pkg.sv | 33 +++
 rtl/word_fifo.sv | 75 +++++++
 rtl/hex_reporter.sv | 151 +++++++++++++++
 tb/tb_hex_reporter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_reporter_pkg.sv
// Shared definitions for the hex reporter: sequencer state encoding, ASCII
// constants and the nibble-to-ASCII helper.
//
// Optional feature macro (used by hex_reporter): HEX_REPORTER_CRLF_EN selects a
// CR LF terminator instead of a single space.
package hex_reporter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StGuard,
    StWait
  } seq_state_e;

  localparam logic [7:0] AsciiZero   = 8'h30;
  localparam logic [7:0] AsciiUpperA = 8'h41;
  localparam logic [7:0] AsciiCr     = 8'h0D;
  localparam logic [7:0] AsciiLf     = 8'h0A;
  localparam logic [7:0] AsciiSpace  = 8'h20;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    logic [7:0] nib8;
    nib8 = {4'h0, nibble};
    if (nibble < 4'd10) begin
      return AsciiZero + nib8;
    end else begin
      return AsciiUpperA + nib8 - 8'd10;
    end
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with registered occupancy count.
//
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   push_i         - write wr_data_i at the tail (ignored when full)
//   wr_data_i      - word to write
//   pop_i          - advance the head (ignored when empty)
//   rd_data_o      - word at the head (valid when not empty)
//   count_o        - registered number of stored words
//   full_o/empty_o - derived from count_o only
module word_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CntW-1:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_en, pop_en;

  assign full_o    = (count_q == CntW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Full is taken from the registered count, so a same-cycle pop never
  // makes room for a same-cycle push.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only read when count is non-zero.
  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/hex_reporter.sv
// Buffers words in a FIFO and reports each one to a UART transmitter as
// uppercase ASCII hex, most-significant nibble first, followed by a terminator.
//
// Configuration macro: HEX_REPORTER_CRLF_EN -- when defined the terminator is
// CR LF (0x0D 0x0A); otherwise it is a single space (0x20).
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   word_valid, word_data - producer word offer
//   word_ready            - FIFO not full
//   tx_en, tx_data        - one-cycle start pulse and byte for the transmitter
//   tx_busy               - transmitter busy flag
//   overflow              - sticky: a word was offered while full
//   idle                  - FIFO empty and sequencer idle
module hex_reporter
  import hex_reporter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              word_ready,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              overflow,
  output logic              idle
);

  localparam int unsigned NumNibbles = DATA_W / 4;
`ifdef HEX_REPORTER_CRLF_EN
  localparam int unsigned TermLen = 2;
`else
  localparam int unsigned TermLen = 1;
`endif
  localparam int unsigned NumChars = NumNibbles + TermLen;
  localparam int unsigned CharW    = $clog2(NumChars + 1);
  localparam int unsigned CntW     = $clog2(DEPTH) + 1;

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CharW-1:0]  char_cnt_q, char_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              overflow_q;
  logic [7:0]        cur_char;

  logic              fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;

  assign word_ready = !fifo_full;
  assign fifo_push  = word_valid && word_ready;

  word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_word_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (fifo_push),
    .wr_data_i (word_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Character selected by the counter: hex digits come from the top nibble of
  // the shift register, which is shifted left after each digit is sent.
  always_comb begin
    if (char_cnt_q < CharW'(NumNibbles)) begin
      cur_char = nibble_to_ascii(shift_q[DATA_W-1 -: 4]);
`ifdef HEX_REPORTER_CRLF_EN
    end else if (char_cnt_q == CharW'(NumNibbles)) begin
      cur_char = AsciiCr;
    end else begin
      cur_char = AsciiLf;
    end
`else
    end else begin
      cur_char = AsciiSpace;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    char_cnt_d = char_cnt_q;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
    tx_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StLoad;
      end
      StLoad: begin
        fifo_pop   = 1'b1;
        shift_d    = fifo_rd_data;
        char_cnt_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        tx_en      = 1'b1;
        tx_data_d  = cur_char;
        char_cnt_d = char_cnt_q + CharW'(1);
        if (char_cnt_q < CharW'(NumNibbles)) shift_d = shift_q << 4;
        state_d    = StGuard;
      end
      // Gives the transmitter a cycle to raise tx_busy.
      StGuard: begin
        state_d = StWait;
      end
      StWait: begin
        if (!tx_busy) begin
          state_d = (char_cnt_q < CharW'(NumChars)) ? StSend : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // tx_data follows the current character in SEND and holds afterwards.
  assign tx_data  = tx_data_d;
  assign overflow = overflow_q;
  assign idle     = (fifo_count == '0) && (state_q == StIdle);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      char_cnt_q <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      char_cnt_q <= char_cnt_d;
      tx_data_q  <= tx_data_d;
      if (word_valid && !word_ready) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_reporter.sv
module tb_hex_reporter;

`ifdef HEX_REPORTER_CRLF_EN
  localparam int TermLen = 2;
`else
  localparam int TermLen = 1;
`endif
  localparam int CharsPerWord = 8 + TermLen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        overflow;
  logic        idle;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  hex_reporter #(
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .overflow   (overflow),
    .idle       (idle)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) begin
    if (tx_en === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] term_char(input int k);
`ifdef HEX_REPORTER_CRLF_EN
    return (k == 0) ? 8'h0D : 8'h0A;
`else
    return (k == 0) ? 8'h20 : 8'h20;
`endif
  endfunction

  function automatic logic [7:0] hex_char(input logic [31:0] value, input int i);
    logic [31:0] v;
    logic [3:0]  nib;
    v   = value >> (28 - 4 * i);
    nib = v[3:0];
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Waits (bounded) for the next tx_en, checks the byte, then plays the
  // transmitter by holding tx_busy for busy_len cycles.
  task automatic expect_char(input string tag, input logic [7:0] exp, input int busy_len,
                             output int waited);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (tx_en !== 1'b1 && waited < 100);
    check(tag, {23'h0, tx_en, tx_data}, {23'h0, 1'b1, exp});
    if (busy_len > 0) begin
      tx_busy = 1'b1;
      repeat (busy_len) @(negedge clock);
      tx_busy = 1'b0;
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] value, input int start,
                             input int busy_len);
    int w;
    for (int i = start; i < CharsPerWord; i++) begin
      expect_char(tag, (i < 8) ? hex_char(value, i) : term_char(i - 8), busy_len, w);
    end
  endtask

  task automatic push_word(input logic [31:0] value);
    @(negedge clock);
    word_valid = 1'b1;
    word_data  = value;
    @(negedge clock);
    word_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  exp_1234 [8];
    logic [7:0]  exp_000a [8];
    logic [31:0] ovf_words [6];
    int          base;
    int          w;

    exp_1234 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
    exp_000a = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41};
    ovf_words = '{32'h89ABCDEF, 32'h01234567, 32'h76543210,
                  32'hFEDCBA98, 32'h13579BDF, 32'h2468ACE0};

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_tx_en", {31'h0, tx_en}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_word_ready", {31'h0, word_ready}, 32'h1);
    check("rst_idle", {31'h0, idle}, 32'h1);

    // 0x1234ABCD with a slow transmitter
    base = pulse_cnt;
    push_word(32'h1234ABCD);
    check("busy_idle_low", {31'h0, idle}, 32'h0);
    for (int i = 0; i < 8; i++) expect_char("w1234_digit", exp_1234[i], 10, w);
    for (int k = 0; k < TermLen; k++) expect_char("w1234_term", term_char(k), 10, w);
    repeat (5) @(negedge clock);
    check("w1234_idle", {31'h0, idle}, 32'h1);
    check("w1234_pulses", pulse_cnt - base, CharsPerWord);
    check("w1234_tx_hold", {24'h0, tx_data}, {24'h0, term_char(TermLen - 1)});

    // All-zero then all-F, back to back, transmitter never busy
    base = pulse_cnt;
    @(negedge clock);
    word_valid = 1'b1;
    word_data  = 32'h00000000;
    @(negedge clock);
    word_data  = 32'hFFFFFFFF;
    @(negedge clock);
    word_valid = 1'b0;
    expect_char("w0_digit", 8'h30, 0, w);
    for (int i = 1; i < 8; i++) begin
      expect_char("w0_digit", 8'h30, 0, w);
      check("min_spacing", w, 3);
    end
    for (int k = 0; k < TermLen; k++) expect_char("w0_term", term_char(k), 0, w);
    for (int i = 0; i < 8; i++) expect_char("wf_digit", 8'h46, 0, w);
    for (int k = 0; k < TermLen; k++) expect_char("wf_term", term_char(k), 0, w);
    repeat (5) @(negedge clock);
    check("w0f_pulses", pulse_cnt - base, 2 * CharsPerWord);
    check("w0f_idle", {31'h0, idle}, 32'h1);

    // Overflow with the transmitter held busy: one word is taken by the
    // sequencer, four fill the FIFO, the sixth is dropped.
    base = pulse_cnt;
    @(negedge clock);
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 5) check("full_word_ready", {31'h0, word_ready}, 32'h0);
      word_valid = 1'b1;
      word_data  = ovf_words[i];
    end
    @(negedge clock);
    word_valid = 1'b0;
    check("ovf_set", {31'h0, overflow}, 32'h1);
    check("ovf_word_ready", {31'h0, word_ready}, 32'h0);
    repeat (200) @(negedge clock);
    check("busy_hold_pulses", pulse_cnt - base, 1);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);
    tx_busy = 1'b0;
    expect_char("busy_release", hex_char(ovf_words[0], 1), 0, w);
    check("busy_release_lat", w, 1);
    expect_word("ovf_w0", ovf_words[0], 2, 0);
    for (int i = 1; i < 5; i++) expect_word("ovf_wn", ovf_words[i], 0, 0);
    repeat (20) @(negedge clock);
    check("ovf_pulses", pulse_cnt - base, 5 * CharsPerWord);
    check("ovf_drain_idle", {31'h0, idle}, 32'h1);
    check("ovf_drain_ready", {31'h0, word_ready}, 32'h1);
    check("ovf_still_set", {31'h0, overflow}, 32'h1);

    // Reset mid-frame after the third character of 0xDEADBEEF
    base = pulse_cnt;
    push_word(32'hDEADBEEF);
    expect_char("dead_c0", 8'h44, 0, w);
    expect_char("dead_c1", 8'h45, 0, w);
    expect_char("dead_c2", 8'h41, 0, w);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_tx_en", {31'h0, tx_en}, 32'h0);
    check("midrst_tx_data", {24'h0, tx_data}, 32'h0);
    check("midrst_idle", {31'h0, idle}, 32'h1);
    check("midrst_ready", {31'h0, word_ready}, 32'h1);
    check("midrst_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    check("midrst_pulses", pulse_cnt - base, 3);
    check("midrst_idle_after", {31'h0, idle}, 32'h1);

    // 0x0000000A
    base = pulse_cnt;
    push_word(32'h0000000A);
    for (int i = 0; i < 8; i++) expect_char("w000a_digit", exp_000a[i], 2, w);
    for (int k = 0; k < TermLen; k++) expect_char("w000a_term", term_char(k), 2, w);
    repeat (10) @(negedge clock);
    check("w000a_pulses", pulse_cnt - base, CharsPerWord);
    check("w000a_idle", {31'h0, idle}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
